// File: rtl/mem_bus_pkg.sv
// Shared constants and types for the two-master memory-bus arbiter.
// Type codes encode (bytes - 1) of the access.
package mem_bus_pkg;

  localparam int MB_ADDR_W = 32;
  localparam int MB_DATA_W = 128;
  localparam int MB_TYPE_W = 4;
  localparam int MB_STRB_W = 16;
  localparam int MB_WD_W   = 16;

  localparam logic [3:0] MB_B1 = 4'd0;
  localparam logic [3:0] MB_B2 = 4'd1;
  localparam logic [3:0] MB_W1 = 4'd3;
  localparam logic [3:0] MB_W2 = 4'd7;
  localparam logic [3:0] MB_W4 = 4'd15;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_ISSUE = 2'd1,
    RD_WAIT  = 2'd2
  } rd_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_bus_arb_rr_arb2.sv
// Two-requester round-robin picker; bit 0 is the I side, bit 1 the D side.
// The pointer moves to the other requester whenever a grant is issued.
module rr_arb2
  import mem_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  owner_e     ptr_r;
  logic [1:0] gnt_s;

  // Pick a winner among the active requesters, pointer breaks ties
  always_comb begin
    gnt_s = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt_s = 2'b01;
        2'b10:   gnt_s = 2'b10;
        2'b11:   gnt_s = (ptr_r == OWN_I) ? 2'b01 : 2'b10;
        default: gnt_s = 2'b00;
      endcase
    end else begin
      gnt_s = 2'b00;
    end
  end

  // Advance the pointer past whoever was just granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= OWN_I;
    end else if (gnt_s[0]) begin
      ptr_r <= OWN_D;
    end else if (gnt_s[1]) begin
      ptr_r <= OWN_I;
    end
  end

  assign gnt = gnt_s;

endmodule

// File: rtl/mem_bus_arb.sv
// Shares the bridge read port between I-fetch and load/store, one read in flight.
// D writes pass straight through; a D read waits while a write is pending.
module mem_bus_arb
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = MB_ADDR_W,
  parameter int DATA_W = MB_DATA_W,
  parameter int TYPE_W = MB_TYPE_W,
  parameter int STRB_W = MB_STRB_W,
  parameter int TO_CYC = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_r_req,
  input  logic [TYPE_W-1:0] i_r_type,
  input  logic [ADDR_W-1:0] i_r_addr,
  output logic              i_r_rdy,
  output logic [DATA_W-1:0] i_re_data,
  output logic              i_re_valid,
  input  logic              d_r_req,
  input  logic [TYPE_W-1:0] d_r_type,
  input  logic [ADDR_W-1:0] d_r_addr,
  output logic              d_r_rdy,
  output logic [DATA_W-1:0] d_re_data,
  output logic              d_re_valid,
  input  logic              d_iw_req,
  input  logic [TYPE_W-1:0] d_iw_type,
  input  logic [ADDR_W-1:0] d_iw_addr,
  input  logic [STRB_W-1:0] d_iw_strb,
  input  logic [DATA_W-1:0] d_iw_data,
  output logic              d_iw_rdy,
  output logic              r_req,
  output logic [TYPE_W-1:0] r_type,
  output logic [ADDR_W-1:0] r_addr,
  input  logic              r_rdy,
  input  logic [DATA_W-1:0] re_data,
  input  logic              re_valid,
  output logic              iw_req,
  output logic [TYPE_W-1:0] iw_type,
  output logic [ADDR_W-1:0] iw_addr,
  output logic [STRB_W-1:0] iw_strb,
  output logic [DATA_W-1:0] iw_data,
  input  logic              iw_rdy,
  output logic              rd_timeout
);

  localparam logic [MB_WD_W-1:0] TO_LIM = MB_WD_W'(TO_CYC);

  rd_state_e          state_r;
  owner_e             owner_r;
  logic [TYPE_W-1:0]  type_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [MB_WD_W-1:0] cnt_r;
  logic               tmo_r;
  logic               idle_s;
  logic               d_ok_s;
  logic               wait_hit_s;
  logic [1:0]         gnt_s;

  assign idle_s = (state_r == RD_IDLE);
  // A D read must not overtake a write that is pending or cannot yet be taken
  assign d_ok_s = d_r_req & iw_rdy & ~d_iw_req;

  rr_arb2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (idle_s),
    .req   ({d_ok_s, i_r_req}),
    .gnt   (gnt_s)
  );

  assign i_r_rdy = gnt_s[0];
  assign d_r_rdy = gnt_s[1];

  // Read FSM: latch the winner, hold the request until the bridge takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RD_IDLE;
      owner_r <= OWN_I;
      type_r  <= '0;
      addr_r  <= '0;
    end else begin
      case (state_r)
        RD_IDLE: begin
          if (gnt_s[0]) begin
            type_r  <= i_r_type;
            addr_r  <= i_r_addr;
            owner_r <= OWN_I;
            state_r <= RD_ISSUE;
          end else if (gnt_s[1]) begin
            type_r  <= d_r_type;
            addr_r  <= d_r_addr;
            owner_r <= OWN_D;
            state_r <= RD_ISSUE;
          end
        end
        RD_ISSUE: if (r_rdy) state_r <= RD_WAIT;
        RD_WAIT:  if (re_valid) state_r <= RD_IDLE;
        default:  state_r <= RD_IDLE;
      endcase
    end
  end

  // Watchdog: counts cycles since issue entry, flag is sticky until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
      tmo_r <= 1'b0;
    end else begin
      if (idle_s && (gnt_s != 2'b00)) begin
        cnt_r <= '0;
      end else if (!idle_s && (cnt_r != {MB_WD_W{1'b1}})) begin
        cnt_r <= cnt_r + 16'd1;
      end
      if (!idle_s && ((cnt_r + 16'd1) >= TO_LIM)) begin
        tmo_r <= 1'b1;
      end
    end
  end

  assign r_req  = (state_r == RD_ISSUE);
  assign r_type = type_r;
  assign r_addr = addr_r;

  // Responses are steered only by valid; data fans out to both masters
  assign wait_hit_s = (state_r == RD_WAIT) & re_valid;
  assign i_re_valid = wait_hit_s & (owner_r == OWN_I);
  assign d_re_valid = wait_hit_s & (owner_r == OWN_D);
  assign i_re_data  = re_data;
  assign d_re_data  = re_data;

  assign iw_req   = d_iw_req;
  assign iw_type  = d_iw_type;
  assign iw_addr  = d_iw_addr;
  assign iw_strb  = d_iw_strb;
  assign iw_data  = d_iw_data;
  assign d_iw_rdy = iw_rdy;

  assign rd_timeout = tmo_r;

endmodule

// File: tb/tb_mem_bus_arb.sv
// Self-checking bench for mem_bus_arb: transaction-level model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_mem_bus_arb;

  localparam int TO = 20;

  logic         clk, rst_n;
  logic         i_r_req, i_r_rdy, i_re_valid;
  logic [3:0]   i_r_type;
  logic [31:0]  i_r_addr;
  logic [127:0] i_re_data;
  logic         d_r_req, d_r_rdy, d_re_valid;
  logic [3:0]   d_r_type;
  logic [31:0]  d_r_addr;
  logic [127:0] d_re_data;
  logic         d_iw_req, d_iw_rdy;
  logic [3:0]   d_iw_type;
  logic [31:0]  d_iw_addr;
  logic [15:0]  d_iw_strb;
  logic [127:0] d_iw_data;
  logic         r_req, r_rdy, re_valid;
  logic [3:0]   r_type;
  logic [31:0]  r_addr;
  logic [127:0] re_data;
  logic         iw_req, iw_rdy;
  logic [3:0]   iw_type;
  logic [31:0]  iw_addr;
  logic [15:0]  iw_strb;
  logic [127:0] iw_data;
  logic         rd_timeout;

  int n_pass = 0;
  int n_total = 0;
  logic grant_q[$];

  // Model state: one pending read transaction
  logic         m_busy, m_sent, m_own, m_pref, m_tmo;
  logic [3:0]   m_type;
  logic [31:0]  m_addr;
  int           m_age;

  mem_bus_arb #(.TO_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_r_req(i_r_req), .i_r_type(i_r_type), .i_r_addr(i_r_addr), .i_r_rdy(i_r_rdy),
    .i_re_data(i_re_data), .i_re_valid(i_re_valid),
    .d_r_req(d_r_req), .d_r_type(d_r_type), .d_r_addr(d_r_addr), .d_r_rdy(d_r_rdy),
    .d_re_data(d_re_data), .d_re_valid(d_re_valid),
    .d_iw_req(d_iw_req), .d_iw_type(d_iw_type), .d_iw_addr(d_iw_addr),
    .d_iw_strb(d_iw_strb), .d_iw_data(d_iw_data), .d_iw_rdy(d_iw_rdy),
    .r_req(r_req), .r_type(r_type), .r_addr(r_addr), .r_rdy(r_rdy),
    .re_data(re_data), .re_valid(re_valid),
    .iw_req(iw_req), .iw_type(iw_type), .iw_addr(iw_addr), .iw_strb(iw_strb),
    .iw_data(iw_data), .iw_rdy(iw_rdy),
    .rd_timeout(rd_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rreq(input int max);
    int n;
    n = 0;
    while (!r_req && n < max) begin
      tick();
      n++;
    end
    chk("r_req_seen", 128'(r_req), 128'(1'b1));
  endtask

  task automatic serve(input logic [127:0] data, input int lat, input logic own);
    wait_rreq(40);
    r_rdy = 1'b1;
    tick();
    r_rdy = 1'b0;
    repeat (lat) tick();
    re_data  = data;
    re_valid = 1'b1;
    @(negedge clk);
    chk("serve_i_valid", 128'(i_re_valid), 128'(!own));
    chk("serve_d_valid", 128'(d_re_valid), 128'(own));
    chk("serve_data", own ? d_re_data : i_re_data, data);
    tick();
    re_valid = 1'b0;
  endtask

  // Per-cycle model compare, then advance the model across the coming edge
  always @(negedge clk) begin
    logic dok, win_v, win_d;
    if (!rst_n) begin
      m_busy = 1'b0; m_sent = 1'b0; m_own = 1'b0; m_pref = 1'b0; m_tmo = 1'b0;
      m_type = 4'd0; m_addr = 32'd0; m_age = 0;
    end
    dok   = d_r_req & iw_rdy & ~d_iw_req;
    win_v = !m_busy && (i_r_req || dok);
    win_d = (i_r_req && dok) ? m_pref : dok;
    chk("m_i_r_rdy", 128'(i_r_rdy), 128'(win_v && !win_d));
    chk("m_d_r_rdy", 128'(d_r_rdy), 128'(win_v && win_d));
    chk("m_r_req", 128'(r_req), 128'(m_busy && !m_sent));
    chk("m_r_type", 128'(r_type), 128'(m_type));
    chk("m_r_addr", 128'(r_addr), 128'(m_addr));
    chk("m_i_re_valid", 128'(i_re_valid), 128'(m_busy && m_sent && re_valid && !m_own));
    chk("m_d_re_valid", 128'(d_re_valid), 128'(m_busy && m_sent && re_valid && m_own));
    chk("m_i_re_data", i_re_data, re_data);
    chk("m_d_re_data", d_re_data, re_data);
    chk("m_iw_req", 128'(iw_req), 128'(d_iw_req));
    chk("m_iw_type", 128'(iw_type), 128'(d_iw_type));
    chk("m_iw_addr", 128'(iw_addr), 128'(d_iw_addr));
    chk("m_iw_strb", 128'(iw_strb), 128'(d_iw_strb));
    chk("m_iw_data", iw_data, d_iw_data);
    chk("m_d_iw_rdy", 128'(d_iw_rdy), 128'(iw_rdy));
    chk("m_rd_timeout", 128'(rd_timeout), 128'(m_tmo));
    if (i_r_rdy) grant_q.push_back(1'b0);
    if (d_r_rdy) grant_q.push_back(1'b1);
    if (rst_n) begin
      if (win_v) begin
        m_busy = 1'b1; m_sent = 1'b0; m_own = win_d; m_age = 0;
        m_type = win_d ? d_r_type : i_r_type;
        m_addr = win_d ? d_r_addr : i_r_addr;
        m_pref = !win_d;
      end else if (m_busy) begin
        m_age++;
        if (m_age >= TO) m_tmo = 1'b1;
        if (!m_sent) begin
          if (r_rdy) m_sent = 1'b1;
        end else if (re_valid) begin
          m_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n = 1'b0;
    i_r_req = 1'b0; i_r_type = 4'd0; i_r_addr = 32'd0;
    d_r_req = 1'b0; d_r_type = 4'd0; d_r_addr = 32'd0;
    d_iw_req = 1'b0; d_iw_type = 4'd0; d_iw_addr = 32'd0; d_iw_strb = 16'd0; d_iw_data = 128'd0;
    r_rdy = 1'b0; re_valid = 1'b0; re_data = 128'd0; iw_rdy = 1'b1;

    // Reset state
    repeat (2) tick();
    @(negedge clk);
    chk("rst_r_req", 128'(r_req), 128'(1'b0));
    chk("rst_timeout", 128'(rd_timeout), 128'(1'b0));
    chk("rst_r_addr", 128'(r_addr), 128'(32'd0));
    tick();
    rst_n = 1'b1;

    // Reset preference and fairness: both request continuously
    i_r_req = 1'b1; i_r_type = 4'd15; i_r_addr = 32'h1000_0000;
    d_r_req = 1'b1; d_r_type = 4'd3;  d_r_addr = 32'h2000_0000;
    @(negedge clk);
    chk("t1_i_first", 128'(i_r_rdy), 128'(1'b1));
    chk("t1_d_not_first", 128'(d_r_rdy), 128'(1'b0));
    tick();
    @(negedge clk);
    chk("t1_r_req", 128'(r_req), 128'(1'b1));
    chk("t1_r_addr", 128'(r_addr), 128'(32'h1000_0000));
    for (int k = 0; k < 8; k++) begin
      serve({96'(k), 32'hDEADBEEF}, (k % 3) + 1, (k % 2) == 1);
    end
    i_r_req = 1'b0;
    d_r_req = 1'b0;

    // Write-before-read ordering under write back-pressure
    d_iw_req = 1'b1; d_iw_type = 4'd15; d_iw_addr = 32'h3000_0100;
    d_iw_strb = 16'h00FF; d_iw_data = 128'hA5A5_5A5A_0123_4567_89AB_CDEF_F0E1_D2C3;
    d_r_req = 1'b1; d_r_type = 4'd7; d_r_addr = 32'h2000_0080;
    iw_rdy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t3_d_blocked", 128'(d_r_rdy), 128'(1'b0));
      chk("t3_iw_addr", 128'(iw_addr), 128'(32'h3000_0100));
      chk("t3_iw_data", iw_data, 128'hA5A5_5A5A_0123_4567_89AB_CDEF_F0E1_D2C3);
      chk("t3_iw_rdy", 128'(d_iw_rdy), 128'(1'b0));
      tick();
    end
    iw_rdy = 1'b1;
    @(negedge clk);
    chk("t3_write_taken", 128'(d_iw_rdy), 128'(1'b1));
    chk("t3_read_waits", 128'(d_r_rdy), 128'(1'b0));
    tick();
    d_iw_req = 1'b0;
    @(negedge clk);
    chk("t3_read_granted", 128'(d_r_rdy), 128'(1'b1));
    tick();
    d_r_req = 1'b0;
    serve(128'h0000_1111_2222_3333_4444_5555_6666_7777, 2, 1'b1);
    chk("t3_r_addr", 128'(r_addr), 128'(32'h2000_0080));
    chk("t3_r_type", 128'(r_type), 128'(4'd7));

    // Bridge back-pressure in ISSUE
    i_r_req = 1'b1; i_r_type = 4'd15; i_r_addr = 32'h8000_0040;
    @(negedge clk);
    chk("t4_grant", 128'(i_r_rdy), 128'(1'b1));
    tick();
    i_r_req = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("t4_r_req_held", 128'(r_req), 128'(1'b1));
      chk("t4_r_type", 128'(r_type), 128'(4'd15));
      chk("t4_r_addr", 128'(r_addr), 128'(32'h8000_0040));
      tick();
    end
    r_rdy = 1'b1;
    @(negedge clk);
    chk("t4_r_req_last", 128'(r_req), 128'(1'b1));
    tick();
    r_rdy = 1'b0;
    @(negedge clk);
    chk("t4_advanced", 128'(r_req), 128'(1'b0));
    tick();
    re_data = 128'h0000_0000_0000_0000_0000_0000_CAFE_F00D;
    re_valid = 1'b1;
    @(negedge clk);
    chk("t4_i_valid", 128'(i_re_valid), 128'(1'b1));
    chk("t4_no_timeout", 128'(rd_timeout), 128'(1'b0));
    tick();
    re_valid = 1'b0;

    // Watchdog: no response for a long time
    i_r_req = 1'b1; i_r_type = 4'd0; i_r_addr = 32'h4000_0000;
    @(negedge clk);
    chk("t5_grant", 128'(i_r_rdy), 128'(1'b1));
    tick();
    i_r_req = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      r_rdy = (c == 1);
      @(negedge clk);
      chk("t5_timeout", 128'(rd_timeout), 128'(c >= 21));
      tick();
    end
    r_rdy = 1'b0;
    re_data = 128'h0000_0000_0000_0000_0000_0000_0000_0BAD;
    re_valid = 1'b1;
    @(negedge clk);
    chk("t5_late_valid", 128'(i_re_valid), 128'(1'b1));
    tick();
    re_valid = 1'b0;
    @(negedge clk);
    chk("t5_sticky", 128'(rd_timeout), 128'(1'b1));
    tick();

    // Mid-read reset in WAIT
    i_r_req = 1'b1; i_r_type = 4'd0; i_r_addr = 32'h5000_0000;
    @(negedge clk);
    tick();
    i_r_req = 1'b0;
    r_rdy = 1'b1;
    tick();
    r_rdy = 1'b0;
    re_data = 128'h0000_0000_0000_0000_0000_0000_5717_E000;
    re_valid = 1'b1;
    #1;
    chk("t6_live_valid", 128'(i_re_valid), 128'(1'b1));
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 128'(i_re_valid), 128'(1'b0));
    chk("t6_async_r_addr", 128'(r_addr), 128'(32'd0));
    chk("t6_async_timeout", 128'(rd_timeout), 128'(1'b0));
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_stale_i", 128'(i_re_valid), 128'(1'b0));
    chk("t6_stale_d", 128'(d_re_valid), 128'(1'b0));
    chk("t6_r_req", 128'(r_req), 128'(1'b0));
    tick();
    re_valid = 1'b0;
    i_r_req = 1'b1; d_r_req = 1'b1;
    @(negedge clk);
    chk("t6_rr_reset_i", 128'(i_r_rdy), 128'(1'b1));
    tick();
    i_r_req = 1'b0;
    serve(128'h0000_0000_0000_0000_0000_0000_0000_600D, 1, 1'b0);
    d_r_req = 1'b0;

    // Grant history: alternation during the fairness phase
    chk("grant_count", 128'(grant_q.size()), 128'(13));
    for (int k = 0; k < 8; k++) begin
      if (k < grant_q.size()) chk("grant_order", 128'(grant_q[k]), 128'((k % 2) == 1));
    end

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
